dff_pipe_scan: RTL and testbench
================================

Name: dff_pipe_scan

Overview:
- Parametrised pipeline register: DEPTH stages of WIDTH-bit data, each stage with its own valid bit.
- Adds three things to the single-bit D flip-flop cells: a per-stage occupancy counter, a valid-only flush, and a full-array scan chain.
- Sits between the gate-level datapath cells and block-level logic. It is the standard retiming/delay element for netlists simulated with back-annotated timing.

Parameters:
- WIDTH, 8, data bits per stage (>=1)
- DEPTH, 4, number of pipeline stages (>=1)
- RESET_VAL, 0, data value loaded into every stage on reset
- CW, $clog2(DEPTH+1), width of occupancy count (derived; not overridden)

Ports:
- CK  input  1  clock; all state updates on rising edge
- R  input  1  synchronous active-high reset
- E  input  1  advance enable; pipeline shifts one stage when 1
- FL  input  1  flush; clears all valid bits, data retained
- D  input  WIDTH  data into stage 0
- VI  input  1  valid qualifier for D
- SE  input  1  scan enable
- SI  input  1  scan data in
- Q  output  WIDTH  data of stage DEPTH-1
- VO  output  1  valid of stage DEPTH-1
- CNT  output  CW  number of valid stages currently held (0..DEPTH)
- SO  output  1  scan data out = stage[DEPTH-1] bit WIDTH-1

Behaviour:
- Reset: one clock is CK; R is synchronous and active-high, sampled on CK rising edge. When R=1, every stage loads RESET_VAL, all valid bits clear to 0 and CNT goes to 0. After reset, Q=RESET_VAL, VO=0, CNT=0, SO=RESET_VAL[WIDTH-1].
- Priority per edge: R > FL > SE > E > hold.
- FL=1 (R=0):
  - all valid bits go to 0 and CNT goes to 0; data stages hold.
  - E, SE and VI are ignored that cycle.
- SE=1 (R=0, FL=0): the whole data array shifts as one serial chain of DEPTH*WIDTH bits.
  - Chain order: SI -> stage0 bit0 -> stage0 bit1 ... stage0 bit WIDTH-1 -> stage1 bit0 ... -> stage DEPTH-1 bit WIDTH-1 -> SO.
  - Valid bits and CNT hold; E is ignored.
  - A full scan load or unload takes DEPTH*WIDTH cycles.
- E=1, SE=0 (R=0, FL=0):
  - stage0 <= D and valid0 <= VI.
  - stage k <= stage k-1 and valid k <= valid k-1, for k=1..DEPTH-1.
  - CNT_next = CNT + VI - valid[DEPTH-1]. All four combinations are legal, and CNT never leaves 0..DEPTH.
- E=0, SE=0: everything holds; CNT unchanged.
- Latency: data presented with E=1 appears on Q after exactly DEPTH enabled edges. Stalled edges (E=0) do not count toward latency.
- DEPTH=1: CNT is 1 bit. Q/VO follow D/VI one enabled edge later.
- Outputs Q, VO, CNT and SO are driven directly from registers; no combinational path from any input.
- Reset asserted mid-scan or mid-stream discards all in-flight data. A partially shifted scan pattern is lost.
- X on E, SE or FL (timing-free build): the affected registers go to X, matching the pessimistic behaviour of the library flop primitive.

Optional Feature:
- Macro: TECH_TIMING_EN
- Defined: the module is compiled as a cell-defined module with a specify block:
  - CK->Q and CK->SO rise/fall path delays 0.14:0.29:0.55 / 0.28:0.46:0.73 ns.
  - $setuphold on D, VI, E, FL, SE, SI and R against posedge CK, setup 0.34 ns, hold 0.29 ns.
  - $width high and low on CK, 0.92 ns.
  - Any violation toggles an internal notifier reg. The notifier drives every stage and valid bit to X, and CNT to X, on the following evaluation.
- Not defined: zero-delay behaviour, no timing checks, notifier absent. Functional behaviour otherwise identical.

Test Plan (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5 unless stated):
- Reset: hold R=1 for 1 edge with random inputs -> Q=8'hA5, VO=0, CNT=0, SO=1.
- Streaming: E=1, VI=1, D=8'h01,02,03,04,05 on 5 edges -> CNT goes 1,2,3,4,4; Q=8'h01 with VO=1 after the 4th edge and 8'h02 after the 5th.
- Stall: hold E=0 for 3 edges mid-stream -> Q, VO and CNT unchanged. The next E=1 edge resumes with no data lost or duplicated.
- Flush: pipeline full (CNT=4), assert FL=1 together with E=1 and VI=1 -> CNT=0, VO=0, Q data unchanged. Next E=1, VI=0 -> CNT stays 0.
- Scan: SE=1, shift 32 bits of 32'hDEADBEEF into SI (LSB first) -> stage contents match the chain order, and the previous contents appear on SO in order. CNT and VO hold throughout.
- Timing (TECH_TIMING_EN defined): change D 0.1 ns before posedge CK -> setup violation reported; Q goes X on the next evaluation. Q transitions 0.29 ns after CK under typical delay.

Source files
------------

// File: rtl/dff_pipe_scan.sv
// Pipeline register of DEPTH x WIDTH stages with per-stage valid, occupancy count,
// valid-only flush and a full-array scan chain. Define TECH_TIMING_EN for the timed cell view.
`ifdef TECH_TIMING_EN
`timescale 1ns/1ps
`celldefine
`endif
module dff_pipe_scan #(
    parameter int unsigned     WIDTH     = 8,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int unsigned     CW        = $clog2(DEPTH + 1)
) (
    input  logic             CK,
    input  logic             R,
    input  logic             E,
    input  logic             FL,
    input  logic [WIDTH-1:0] D,
    input  logic             VI,
    input  logic             SE,
    input  logic             SI,
    output logic [WIDTH-1:0] Q,
    output logic             VO,
    output logic [CW-1:0]    CNT,
    output logic             SO
);

    localparam int unsigned NBITS = DEPTH * WIDTH;

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [DEPTH-1:0][WIDTH-1:0] stage_nxt;
    logic [DEPTH-1:0][WIDTH-1:0] stage_shift;
    logic [DEPTH-1:0][WIDTH-1:0] stage_scan;
    logic [DEPTH-1:0]            valid;
    logic [DEPTH-1:0]            valid_nxt;
    logic [DEPTH-1:0]            valid_shift;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_nxt;
    logic [CW-1:0]               cnt_step;

`ifdef TECH_TIMING_EN
    reg   notifier;
    logic notifier_q;

    always_ff @(posedge CK) notifier_q <= notifier;
`endif

    // Next-state selection; ternaries keep X on a control input pessimistic in simulation.
    always_comb begin
        stage_shift = stage;
        valid_shift = valid;
        for (int k = DEPTH - 1; k > 0; k--) begin
            stage_shift[k] = stage[k-1];
            valid_shift[k] = valid[k-1];
        end
        stage_shift[0] = D;
        valid_shift[0] = VI;

        // Whole array is one serial chain: SI enters stage0 bit0, SO leaves the top bit.
        stage_scan = (stage << 1) | NBITS'(SI);

        cnt_step = cnt + CW'(VI) - CW'(valid[DEPTH-1]);

        stage_nxt = FL ? stage : (SE ? stage_scan : (E ? stage_shift : stage));
        valid_nxt = FL ? '0    : (SE ? valid      : (E ? valid_shift : valid));
        cnt_nxt   = FL ? '0    : (SE ? cnt        : (E ? cnt_step    : cnt));
    end

    // State registers with synchronous reset.
    always_ff @(posedge CK) begin
        if (R) begin
            stage <= {DEPTH{RESET_VAL}};
            valid <= '0;
            cnt   <= '0;
        end else begin
            stage <= stage_nxt;
            valid <= valid_nxt;
            cnt   <= cnt_nxt;
        end
`ifdef TECH_TIMING_EN
        if (notifier !== notifier_q) begin
            stage <= 'x;
            valid <= 'x;
            cnt   <= 'x;
        end
`endif
    end

    assign Q   = stage[DEPTH-1];
    assign VO  = valid[DEPTH-1];
    assign CNT = cnt;
    assign SO  = stage[DEPTH-1][WIDTH-1];

`ifdef TECH_TIMING_EN
    specify
        (CK *> Q)  = (0.14:0.29:0.55, 0.28:0.46:0.73);
        (CK => SO) = (0.14:0.29:0.55, 0.28:0.46:0.73);
        $setuphold(posedge CK, D,  0.34, 0.29, notifier);
        $setuphold(posedge CK, VI, 0.34, 0.29, notifier);
        $setuphold(posedge CK, E,  0.34, 0.29, notifier);
        $setuphold(posedge CK, FL, 0.34, 0.29, notifier);
        $setuphold(posedge CK, SE, 0.34, 0.29, notifier);
        $setuphold(posedge CK, SI, 0.34, 0.29, notifier);
        $setuphold(posedge CK, R,  0.34, 0.29, notifier);
        $width(posedge CK, 0.92, 0, notifier);
        $width(negedge CK, 0.92, 0, notifier);
    endspecify
`endif

endmodule
`ifdef TECH_TIMING_EN
`endcelldefine
`endif

// File: tb/tb_dff_pipe_scan.sv
// Directed self-checking bench for dff_pipe_scan (WIDTH=8, DEPTH=4, RESET_VAL=8'hA5).
module tb_dff_pipe_scan;

    logic       clk;
    logic       r;
    logic       e;
    logic       fl;
    logic [7:0] d;
    logic       vi;
    logic       se;
    logic       si;
    logic [7:0] q;
    logic       vo;
    logic [2:0] cnt;
    logic       so;

    int n_checks = 0;
    int n_pass   = 0;

    dff_pipe_scan #(
        .WIDTH    (8),
        .DEPTH    (4),
        .RESET_VAL(8'hA5)
    ) dut (
        .CK (clk),
        .R  (r),
        .E  (e),
        .FL (fl),
        .D  (d),
        .VI (vi),
        .SE (se),
        .SI (si),
        .Q  (q),
        .VO (vo),
        .CNT(cnt),
        .SO (so)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One active edge, then settle to the falling edge for sampling and driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic en, input logic valid_in, input logic [7:0] data);
        e  = en;
        vi = valid_in;
        d  = data;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] eq, input logic ev, input logic [2:0] ec);
        check({tag, ".q"},   32'(q),   32'(eq));
        check({tag, ".vo"},  32'(vo),  32'(ev));
        check({tag, ".cnt"}, 32'(cnt), 32'(ec));
    endtask

    logic [31:0] pat;
    logic [31:0] chain;
    logic [7:0]  stream_q [5];
    logic        stream_v [5];
    logic [2:0]  stream_c [5];

    initial begin
        stream_q = '{8'hA5, 8'hA5, 8'hA5, 8'h01, 8'h02};
        stream_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        stream_c = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};

        // Reset with arbitrary other inputs.
        r  = 1'b1;
        fl = 1'($urandom);
        se = 1'($urandom);
        si = 1'($urandom);
        drive(1'($urandom), 1'($urandom), 8'($urandom));
        @(negedge clk);
        step();
        expect_out("reset", 8'hA5, 1'b0, 3'd0);
        check("reset.so", 32'(so), 32'(1));

        // Streaming 01..05.
        r  = 1'b0;
        fl = 1'b0;
        se = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b1, 8'(i + 1));
            step();
            expect_out($sformatf("stream%0d", i), stream_q[i], stream_v[i], stream_c[i]);
        end

        // Stall: outputs hold whatever else is presented.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'($urandom), 8'($urandom));
            step();
            expect_out($sformatf("stall%0d", i), 8'h02, 1'b1, 3'd4);
        end
        drive(1'b1, 1'b1, 8'h06);
        step();
        expect_out("resume0", 8'h03, 1'b1, 3'd4);
        drive(1'b1, 1'b1, 8'h07);
        step();
        expect_out("resume1", 8'h04, 1'b1, 3'd4);

        // Flush while full, E and VI asserted: valid clears, data holds.
        fl = 1'b1;
        drive(1'b1, 1'b1, 8'h55);
        step();
        expect_out("flush", 8'h04, 1'b0, 3'd0);
        fl = 1'b0;
        drive(1'b1, 1'b0, 8'h66);
        step();
        expect_out("post_flush", 8'h05, 1'b0, 3'd0);

        // Single valid token travels through; count drops when it leaves.
        drive(1'b1, 1'b1, 8'h10); step(); expect_out("tok0", 8'h06, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 8'h20); step(); expect_out("tok1", 8'h07, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 8'h30); step(); expect_out("tok2", 8'h66, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 8'h40); step(); expect_out("tok3", 8'h10, 1'b1, 3'd1);
        drive(1'b1, 1'b0, 8'h50); step(); expect_out("tok4", 8'h20, 1'b0, 3'd0);
        drive(1'b1, 1'b1, 8'h60); step(); expect_out("tok5", 8'h30, 1'b0, 3'd1);

        // Scan 32'hDEADBEEF LSB first with E held high; old array 32'h30405060 streams out.
        pat   = 32'hDEADBEEF;
        chain = 32'h30405060;
        se    = 1'b1;
        drive(1'b1, 1'b1, 8'hFF);
        for (int i = 0; i < 32; i++) begin
            si    = pat[i];
            chain = {chain[30:0], pat[i]};
            step();
            check($sformatf("scan%0d.so", i), 32'(so), 32'(chain[31]));
            check($sformatf("scan%0d.cnt", i), 32'(cnt), 32'(1));
            check($sformatf("scan%0d.vo", i), 32'(vo), 32'(0));
        end
        // Bit-reversed DEADBEEF is F77DB57B: stage3..stage0 = F7,7D,B5,7B.
        check("scan_done.q", 32'(q), 32'(8'hF7));

        se = 1'b0;
        drive(1'b1, 1'b0, 8'h00); step(); expect_out("unload0", 8'h7D, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 8'h00); step(); expect_out("unload1", 8'hB5, 1'b0, 3'd1);
        drive(1'b1, 1'b0, 8'h00); step(); expect_out("unload2", 8'h7B, 1'b1, 3'd1);

        // Reset mid-scan discards everything.
        r  = 1'b1;
        se = 1'b1;
        si = 1'b0;
        drive(1'b1, 1'b1, 8'h33);
        step();
        expect_out("reset2", 8'hA5, 1'b0, 3'd0);
        check("reset2.so", 32'(so), 32'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
